tank_game_ctrl: RTL and testbench

- Game sequencer between the debounced buttons/joystick and the VGA renderer.
- Runs the game state machine (title/play/pause/over).
- Schedules per-frame tank movement with boundary clamping, and owns a single bullet.
- Outputs drive the renderer's state, tank position/direction and bullet inputs directly.

---
 rtl/tank_game_ctrl.sv | 269 ++++++++++++++++++++++++++
 tb/tb_tank_game_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_game_ctrl.sv
// Game sequencer between the debounced controls and the VGA renderer.
// Owns the title/play/pause/over state machine, the frame-divided tank
// movement with edge clamping, and a single bullet. All outputs are registered.
module tank_game_ctrl #(
    parameter int unsigned X_MAX    = 39,
    parameter int unsigned Y_MAX    = 29,
    parameter int unsigned X_INIT   = 32,
    parameter int unsigned Y_INIT   = 3,
    parameter int unsigned MOVE_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic       i_hit,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    input  logic       i_fire,
    output logic [1:0] o_state,
    output logic [5:0] o_tank_x,
    output logic [5:0] o_tank_y,
    output logic [1:0] o_tank_dir,
    output logic       o_bullet_valid,
    output logic [5:0] o_bullet_x,
    output logic [5:0] o_bullet_y
);

    // Counter is at least one bit wide so MOVE_DIV=1 still elaborates.
    localparam int unsigned CntW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MOVE_DIV - 1);

    localparam logic [5:0] XMax  = 6'(X_MAX);
    localparam logic [5:0] YMax  = 6'(Y_MAX);
    localparam logic [5:0] XInit = 6'(X_INIT);
    localparam logic [5:0] YInit = 6'(Y_INIT);

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirRight = 2'd1;
    localparam logic [1:0] DirDown  = 2'd2;
    localparam logic [1:0] DirLeft  = 2'd3;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPlay  = 2'b01,
        StPause = 2'b10,
        StOver  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        tank_x_q, tank_x_d;
    logic [5:0]        tank_y_q, tank_y_d;
    logic [1:0]        tank_dir_q, tank_dir_d;
    logic              bul_valid_q, bul_valid_d;
    logic [5:0]        bul_x_q, bul_x_d;
    logic [5:0]        bul_y_q, bul_y_d;
    logic [1:0]        bul_dir_q, bul_dir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              fire_pend_q, fire_pend_d;
    logic              fire_prev_q, fire_prev_d;

    logic              fire_rise;
    logic              move_tick;
    logic              tank_req;
    logic [5:0]        tank_step_x;
    logic [5:0]        tank_step_y;
    logic [1:0]        tank_step_dir;
    logic [5:0]        bul_step_x;
    logic [5:0]        bul_step_y;
    logic              bul_step_off;

    assign fire_rise = i_fire & ~fire_prev_q;

    // Candidate tank move for this tick: joystick priority up > down > left > right,
    // direction always follows the stick, position clamps at the playfield edge.
    always_comb begin
        tank_req      = i_up | i_down | i_left | i_right;
        tank_step_x   = tank_x_q;
        tank_step_y   = tank_y_q;
        tank_step_dir = tank_dir_q;
        if (i_up) begin
            tank_step_dir = DirUp;
            if (tank_y_q != 6'd0) begin
                tank_step_y = tank_y_q - 6'd1;
            end
        end else if (i_down) begin
            tank_step_dir = DirDown;
            if (tank_y_q != YMax) begin
                tank_step_y = tank_y_q + 6'd1;
            end
        end else if (i_left) begin
            tank_step_dir = DirLeft;
            if (tank_x_q != 6'd0) begin
                tank_step_x = tank_x_q - 6'd1;
            end
        end else if (i_right) begin
            tank_step_dir = DirRight;
            if (tank_x_q != XMax) begin
                tank_step_x = tank_x_q + 6'd1;
            end
        end
    end

    // Candidate bullet step along its latched direction; flag when it would leave the field.
    always_comb begin
        bul_step_x   = bul_x_q;
        bul_step_y   = bul_y_q;
        bul_step_off = 1'b0;
        unique case (bul_dir_q)
            DirUp: begin
                if (bul_y_q == 6'd0) bul_step_off = 1'b1;
                else                 bul_step_y   = bul_y_q - 6'd1;
            end
            DirRight: begin
                if (bul_x_q == XMax) bul_step_off = 1'b1;
                else                 bul_step_x   = bul_x_q + 6'd1;
            end
            DirDown: begin
                if (bul_y_q == YMax) bul_step_off = 1'b1;
                else                 bul_step_y   = bul_y_q + 6'd1;
            end
            default: begin
                if (bul_x_q == 6'd0) bul_step_off = 1'b1;
                else                 bul_step_x   = bul_x_q - 6'd1;
            end
        endcase
    end

    // Game FSM next state plus per-frame tank/bullet scheduling.
    always_comb begin
        state_d     = state_q;
        tank_x_d    = tank_x_q;
        tank_y_d    = tank_y_q;
        tank_dir_d  = tank_dir_q;
        bul_valid_d = bul_valid_q;
        bul_x_d     = bul_x_q;
        bul_y_d     = bul_y_q;
        bul_dir_d   = bul_dir_q;
        cnt_d       = cnt_q;
        fire_pend_d = fire_pend_q;
        fire_prev_d = i_fire;
        move_tick   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d     = StPlay;
                    tank_x_d    = XInit;
                    tank_y_d    = YInit;
                    tank_dir_d  = DirUp;
                    cnt_d       = '0;
                    bul_valid_d = 1'b0;
                    bul_x_d     = 6'd0;
                    bul_y_d     = 6'd0;
                    bul_dir_d   = DirUp;
                    fire_pend_d = 1'b0;
                end
            end

            StPlay: begin
                if (i_hit) begin
                    state_d     = StOver;
                    bul_valid_d = 1'b0;
                    bul_x_d     = 6'd0;
                    bul_y_d     = 6'd0;
                    bul_dir_d   = DirUp;
                    fire_pend_d = 1'b0;
                end else if (i_pause) begin
                    state_d     = StPause;
                    fire_pend_d = 1'b0;
                end else begin
                    if (i_frame) begin
                        if (cnt_q == CntLast) begin
                            move_tick = 1'b1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end

                        if (move_tick && tank_req) begin
                            tank_x_d   = tank_step_x;
                            tank_y_d   = tank_step_y;
                            tank_dir_d = tank_step_dir;
                        end

                        if (bul_valid_q) begin
                            // A pending shot while a bullet is in flight is dropped.
                            fire_pend_d = 1'b0;
                            if (bul_step_off) begin
                                bul_valid_d = 1'b0;
                            end else begin
                                bul_x_d = bul_step_x;
                                bul_y_d = bul_step_y;
                            end
                        end else if (fire_pend_q) begin
                            // Spawn at the pre-tick tank position; no step this frame.
                            bul_valid_d = 1'b1;
                            bul_x_d     = tank_x_q;
                            bul_y_d     = tank_y_q;
                            bul_dir_d   = tank_dir_q;
                            fire_pend_d = 1'b0;
                        end
                    end
                    // An edge on a frame cycle is kept for the next frame.
                    if (fire_rise) begin
                        fire_pend_d = 1'b1;
                    end
                end
            end

            StPause: begin
                if (i_pause) begin
                    state_d = StPlay;
                end
            end

            StOver: begin
                if (i_start) begin
                    state_d     = StIdle;
                    fire_pend_d = 1'b0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            tank_x_q    <= XInit;
            tank_y_q    <= YInit;
            tank_dir_q  <= DirUp;
            bul_valid_q <= 1'b0;
            bul_x_q     <= 6'd0;
            bul_y_q     <= 6'd0;
            bul_dir_q   <= DirUp;
            cnt_q       <= '0;
            fire_pend_q <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tank_x_q    <= tank_x_d;
            tank_y_q    <= tank_y_d;
            tank_dir_q  <= tank_dir_d;
            bul_valid_q <= bul_valid_d;
            bul_x_q     <= bul_x_d;
            bul_y_q     <= bul_y_d;
            bul_dir_q   <= bul_dir_d;
            cnt_q       <= cnt_d;
            fire_pend_q <= fire_pend_d;
            fire_prev_q <= fire_prev_d;
        end
    end

    assign o_state        = state_q;
    assign o_tank_x       = tank_x_q;
    assign o_tank_y       = tank_y_q;
    assign o_tank_dir     = tank_dir_q;
    assign o_bullet_valid = bul_valid_q;
    assign o_bullet_x     = bul_x_q;
    assign o_bullet_y     = bul_y_q;

endmodule

// File: tb/tb_tank_game_ctrl.sv
// Directed bench for tank_game_ctrl: a behavioural game model pushes the expected
// outputs for every driven cycle; they are popped and checked after the clock edge.
module tb_tank_game_ctrl;

    localparam int X_MAX    = 39;
    localparam int Y_MAX    = 29;
    localparam int X_INIT   = 32;
    localparam int Y_INIT   = 3;
    localparam int MOVE_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_frame, i_start, i_pause, i_hit;
    logic       i_up, i_down, i_left, i_right, i_fire;
    logic [1:0] o_state;
    logic [5:0] o_tank_x, o_tank_y;
    logic [1:0] o_tank_dir;
    logic       o_bullet_valid;
    logic [5:0] o_bullet_x, o_bullet_y;

    always #5 clk = ~clk;

    tank_game_ctrl #(
        .X_MAX   (X_MAX),
        .Y_MAX   (Y_MAX),
        .X_INIT  (X_INIT),
        .Y_INIT  (Y_INIT),
        .MOVE_DIV(MOVE_DIV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_frame       (i_frame),
        .i_start       (i_start),
        .i_pause       (i_pause),
        .i_hit         (i_hit),
        .i_up          (i_up),
        .i_down        (i_down),
        .i_left        (i_left),
        .i_right       (i_right),
        .i_fire        (i_fire),
        .o_state       (o_state),
        .o_tank_x      (o_tank_x),
        .o_tank_y      (o_tank_y),
        .o_tank_dir    (o_tank_dir),
        .o_bullet_valid(o_bullet_valid),
        .o_bullet_x    (o_bullet_x),
        .o_bullet_y    (o_bullet_y)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [5:0] tx;
        logic [5:0] ty;
        logic [1:0] dir;
        logic       bv;
        logic [5:0] bx;
        logic [5:0] by;
    } exp_t;

    exp_t exp_q[$];
    exp_t m;
    int   m_cnt;
    int   m_bdir;
    logic m_pend;
    logic m_prev;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.st  = 2'd0;
        m.tx  = 6'(X_INIT);
        m.ty  = 6'(Y_INIT);
        m.dir = 2'd0;
        m.bv  = 1'b0;
        m.bx  = 6'd0;
        m.by  = 6'd0;
        m_cnt  = 0;
        m_bdir = 0;
        m_pend = 1'b0;
        m_prev = 1'b0;
    endtask

    // Reference game behaviour for one clock edge, from the pre-edge model state.
    task automatic model_step(input logic fr, input logic st, input logic pa, input logic hi);
        exp_t n;
        int   nc;
        int   nbdir;
        logic npend;
        logic rise;
        n = m; nc = m_cnt; nbdir = m_bdir; npend = m_pend;
        rise = i_fire && !m_prev;
        case (m.st)
            2'd0: if (st) begin
                n.st = 2'd1; n.tx = 6'(X_INIT); n.ty = 6'(Y_INIT); n.dir = 2'd0;
                n.bv = 1'b0; n.bx = 6'd0; n.by = 6'd0; nc = 0; npend = 1'b0;
            end
            2'd1: begin
                if (hi) begin
                    n.st = 2'd3; n.bv = 1'b0; n.bx = 6'd0; n.by = 6'd0; npend = 1'b0;
                end else if (pa) begin
                    n.st = 2'd2; npend = 1'b0;
                end else begin
                    if (fr) begin
                        if (m_cnt == MOVE_DIV - 1) begin
                            nc = 0;
                            if (i_up) begin
                                n.dir = 2'd0; if (m.ty > 0) n.ty = m.ty - 6'd1;
                            end else if (i_down) begin
                                n.dir = 2'd2; if (m.ty < Y_MAX) n.ty = m.ty + 6'd1;
                            end else if (i_left) begin
                                n.dir = 2'd3; if (m.tx > 0) n.tx = m.tx - 6'd1;
                            end else if (i_right) begin
                                n.dir = 2'd1; if (m.tx < X_MAX) n.tx = m.tx + 6'd1;
                            end
                        end else begin
                            nc = m_cnt + 1;
                        end
                        if (m.bv) begin
                            npend = 1'b0;
                            case (m_bdir)
                                0: if (m.by == 0) n.bv = 1'b0; else n.by = m.by - 6'd1;
                                1: if (m.bx == X_MAX) n.bv = 1'b0; else n.bx = m.bx + 6'd1;
                                2: if (m.by == Y_MAX) n.bv = 1'b0; else n.by = m.by + 6'd1;
                                default: if (m.bx == 0) n.bv = 1'b0; else n.bx = m.bx - 6'd1;
                            endcase
                        end else if (m_pend) begin
                            n.bv = 1'b1; n.bx = m.tx; n.by = m.ty; nbdir = int'(m.dir);
                            npend = 1'b0;
                        end
                    end
                    if (rise) npend = 1'b1;
                end
            end
            2'd2: if (pa) n.st = 2'd1;
            default: if (st) n.st = 2'd0;
        endcase
        m = n; m_cnt = nc; m_bdir = nbdir; m_pend = npend; m_prev = i_fire;
    endtask

    task automatic sb_check(input string lbl);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({lbl, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({lbl, "_state"}, 32'(o_state), 32'(e.st));
            chk({lbl, "_tx"}, 32'(o_tank_x), 32'(e.tx));
            chk({lbl, "_ty"}, 32'(o_tank_y), 32'(e.ty));
            chk({lbl, "_dir"}, 32'(o_tank_dir), 32'(e.dir));
            chk({lbl, "_bv"}, 32'(o_bullet_valid), 32'(e.bv));
            chk({lbl, "_bx"}, 32'(o_bullet_x), 32'(e.bx));
            chk({lbl, "_by"}, 32'(o_bullet_y), 32'(e.by));
        end
    endtask

    // Drive one cycle of pulses (levels are set by the caller), predict, then check.
    task automatic cycle(input string lbl, input logic fr, input logic st,
                         input logic pa, input logic hi);
        @(negedge clk);
        i_frame = fr; i_start = st; i_pause = pa; i_hit = hi;
        model_step(fr, st, pa, hi);
        exp_q.push_back(m);
        @(posedge clk);
        #1;
        i_frame = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_hit = 1'b0;
        sb_check(lbl);
    endtask

    task automatic frames(input string lbl, input int n);
        for (int i = 0; i < n; i++) cycle(lbl, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_stick(input logic u, input logic d, input logic l, input logic r);
        i_up = u; i_down = d; i_left = l; i_right = r;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_frame = 1'b0; i_start = 1'b0; i_pause = 1'b0; i_hit = 1'b0; i_fire = 1'b0;
        set_stick(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_tx", 32'(o_tank_x), 32'd32);
        chk("rst_ty", 32'(o_tank_y), 32'd3);
        chk("rst_bv", 32'(o_bullet_valid), 32'd0);
        rst_n = 1'b1;

        // Hit and pause outside PLAY are ignored.
        cycle("idle_hit", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("idle_pause", 1'b0, 1'b0, 1'b1, 1'b0);
        cycle("start", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("start_state", 32'(o_state), 32'd1);
        chk("start_tx", 32'(o_tank_x), 32'd32);
        chk("start_ty", 32'(o_tank_y), 32'd3);
        chk("start_bv", 32'(o_bullet_valid), 32'd0);
        cycle("play_start", 1'b0, 1'b1, 1'b0, 1'b0);

        // Right held: one cell per MOVE_DIV frames.
        set_stick(1'b0, 1'b0, 1'b0, 1'b1);
        frames("right", 3);
        chk("right3_x", 32'(o_tank_x), 32'd32);
        frames("right", 1);
        chk("right4_x", 32'(o_tank_x), 32'd33);
        chk("right4_dir", 32'(o_tank_dir), 32'd1);
        frames("right", 4);
        chk("right8_x", 32'(o_tank_x), 32'd34);
        chk("right8_y", 32'(o_tank_y), 32'd3);

        // Drive into the right edge and past it.
        frames("to_edge", 20);
        chk("edge_x", 32'(o_tank_x), 32'd39);
        frames("edge_hold", 4);
        chk("edge_hold_x", 32'(o_tank_x), 32'd39);
        chk("edge_hold_dir", 32'(o_tank_dir), 32'd1);

        // Up to the top edge, one extra tick clamps at y=0.
        set_stick(1'b1, 1'b0, 1'b0, 1'b1);
        frames("up", 16);
        chk("top_y", 32'(o_tank_y), 32'd0);
        chk("top_dir", 32'(o_tank_dir), 32'd0);

        // Position at (10,5) facing right.
        set_stick(1'b0, 1'b1, 1'b1, 1'b0);
        frames("down", 20);
        chk("down_y", 32'(o_tank_y), 32'd5);
        set_stick(1'b0, 1'b0, 1'b1, 1'b0);
        frames("left", 120);
        chk("left_x", 32'(o_tank_x), 32'd9);
        set_stick(1'b0, 1'b0, 1'b0, 1'b1);
        frames("right1", 4);
        chk("pos_x", 32'(o_tank_x), 32'd10);
        chk("pos_dir", 32'(o_tank_dir), 32'd1);
        set_stick(1'b0, 1'b0, 1'b0, 1'b0);

        // Fire: spawn at tank position on the next frame, then fly right.
        i_fire = 1'b1;
        cycle("fire_press", 1'b0, 1'b0, 1'b0, 1'b0);
        i_fire = 1'b0;
        cycle("fire_rel", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("prespawn_bv", 32'(o_bullet_valid), 32'd0);
        frames("spawn", 1);
        chk("spawn_bv", 32'(o_bullet_valid), 32'd1);
        chk("spawn_bx", 32'(o_bullet_x), 32'd10);
        chk("spawn_by", 32'(o_bullet_y), 32'd5);
        frames("fly", 2);
        chk("fly2_bx", 32'(o_bullet_x), 32'd12);

        // Second press while in flight is dropped.
        i_fire = 1'b1;
        cycle("fire2_press", 1'b0, 1'b0, 1'b0, 1'b0);
        i_fire = 1'b0;
        frames("fly", 27);
        chk("far_bx", 32'(o_bullet_x), 32'd39);
        chk("far_bv", 32'(o_bullet_valid), 32'd1);
        frames("exit", 1);
        chk("exit_bv", 32'(o_bullet_valid), 32'd0);
        chk("exit_bx", 32'(o_bullet_x), 32'd39);
        frames("no_respawn", 2);
        chk("no_respawn_bv", 32'(o_bullet_valid), 32'd0);

        // Fire then pause before the frame: the shot is lost.
        i_fire = 1'b1;
        cycle("fp_press", 1'b0, 1'b0, 1'b0, 1'b0);
        i_fire = 1'b0;
        cycle("fp_pause", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("paused_state", 32'(o_state), 32'd2);
        set_stick(1'b1, 1'b0, 1'b0, 1'b0);
        frames("paused_frames", 8);
        chk("paused_y", 32'(o_tank_y), 32'd5);
        set_stick(1'b0, 1'b0, 1'b0, 1'b0);
        cycle("fp_unpause", 1'b0, 1'b0, 1'b1, 1'b0);
        frames("fp_frame", 2);
        chk("fp_bv", 32'(o_bullet_valid), 32'd0);

        // Fire edge on a frame cycle is consumed by the following frame.
        i_fire = 1'b1;
        cycle("ff_edge", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ff_edge_bv", 32'(o_bullet_valid), 32'd0);
        frames("ff_next", 1);
        chk("ff_next_bv", 32'(o_bullet_valid), 32'd1);
        i_fire = 1'b0;
        frames("ff_fly", 1);

        // Hit wins over pause; bullet cleared; start returns to IDLE.
        cycle("hit_pause", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("over_state", 32'(o_state), 32'd3);
        chk("over_bv", 32'(o_bullet_valid), 32'd0);
        cycle("over_hit", 1'b0, 1'b0, 1'b0, 1'b1);
        cycle("over_start", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("idle_state", 32'(o_state), 32'd0);

        // Asynchronous reset mid-PLAY.
        cycle("restart", 1'b0, 1'b1, 1'b0, 1'b0);
        set_stick(1'b0, 1'b0, 1'b0, 1'b1);
        frames("pre_rst", 4);
        chk("pre_rst_x", 32'(o_tank_x), 32'd33);
        i_fire = 1'b1;
        frames("pre_rst_fire", 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(o_state), 32'd0);
        chk("arst_tx", 32'(o_tank_x), 32'd32);
        chk("arst_ty", 32'(o_tank_y), 32'd3);
        chk("arst_dir", 32'(o_tank_dir), 32'd0);
        chk("arst_bv", 32'(o_bullet_valid), 32'd0);
        chk("arst_bx", 32'(o_bullet_x), 32'd0);
        chk("arst_by", 32'(o_bullet_y), 32'd0);
        i_fire = 1'b0;
        set_stick(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle("post_rst", 1'b0, 1'b1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
